// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the HI/LO multiply controller:
//   - req_op_e    : request opcode encodings (MULT, MTHI, MTLO, MADD)
//   - state_e     : controller state encoding (IDLE, BUSY)
//   - hilo_cmd_e  : update command from the controller to hilo_reg
//   - WATCHDOG_CYCLES_DEF : default watchdog limit in BUSY cycles
// Optional feature macro: MULT_HILO_MADD_EN (enables the MADD accumulate path).
// -----------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_MTHI = 2'b01,
    OP_MTLO = 2'b10,
    OP_MADD = 2'b11
  } req_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    HILO_NONE  = 3'd0,
    HILO_WR_HI = 3'd1,
    HILO_WR_LO = 3'd2,
    HILO_LOAD  = 3'd3,
    HILO_ACC   = 3'd4
  } hilo_cmd_e;

  localparam int WATCHDOG_CYCLES_DEF = 32;

  // Width of a counter that must hold 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// -----------------------------------------------------------------------------
// hilo_reg
// 64-bit HI/LO storage. Supports 32-bit writes to either half, a full 64-bit
// load of a product and (with MULT_HILO_MADD_EN defined) a modulo-2^64
// accumulate of a product into {hi,lo}.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears HI/LO)
//   cmd       : update command for this edge (hilo_cmd_e)
//   wdata     : 32-bit write data for HILO_WR_HI / HILO_WR_LO
//   prod      : 64-bit product for HILO_LOAD / HILO_ACC
//   hi, lo    : current register contents
// -----------------------------------------------------------------------------
module hilo_reg
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  hilo_cmd_e   cmd,
  input  logic [31:0] wdata,
  input  logic [63:0] prod,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= 64'd0;
    end else begin
      case (cmd)
        HILO_WR_HI: acc_reg[63:32] <= wdata;
        HILO_WR_LO: acc_reg[31:0]  <= wdata;
        HILO_LOAD:  acc_reg        <= prod;
`ifdef MULT_HILO_MADD_EN
        // Plain 64-bit add: wraps silently, no overflow indication.
        HILO_ACC:   acc_reg        <= acc_reg + prod;
`endif
        default:    acc_reg        <= acc_reg;
      endcase
    end
  end

  assign hi = acc_reg[63:32];
  assign lo = acc_reg[31:0];

endmodule

// File: rtl/mult_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// mult_hilo_ctrl
// Request front-end for an external multi-cycle signed 32x32 multiplier with
// architectural HI/LO registers. Two-state FSM (IDLE/BUSY):
//   IDLE : accepts one request per cycle. MTHI/MTLO write HI/LO at the accept
//          edge; MULT/MADD latch operands and raise mult_begin -> BUSY.
//   BUSY : waits for mult_end; a watchdog aborts after WATCHDOG_CYCLES BUSY
//          cycles without mult_end (sets sticky err, HI/LO untouched).
// Optional feature macro: MULT_HILO_MADD_EN
//   defined   : MADD accumulates the product into {hi,lo}
//   undefined : MADD retires immediately as a no-op (done pulse only)
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready high only in IDLE)
//   req_op                : 00 MULT, 01 MTHI, 10 MTLO, 11 MADD
//   req_src1, req_src2    : operands (src1 is write data for MTHI/MTLO)
//   mult_begin            : start/hold to multiplier
//   mult_op1, mult_op2    : registered operands, stable while mult_begin=1
//   product, mult_end     : multiplier result and its (combinational) valid
//   hi, lo                : HI/LO registers
//   done                  : one-cycle pulse when an operation retires
//   err                   : sticky watchdog-abort flag
// -----------------------------------------------------------------------------
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        err
);

  localparam int WD_W = cnt_width(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  state_e          state_reg;
  logic            mult_begin_reg;
  logic [31:0]     op1_reg;
  logic [31:0]     op2_reg;
  logic            done_reg;
  logic            err_reg;
  logic [WD_W-1:0] wd_cnt_reg;
`ifdef MULT_HILO_MADD_EN
  logic            madd_reg;
`endif

  req_op_e   op_in;
  hilo_cmd_e hilo_cmd;

  assign op_in = req_op_e'(req_op);

  // HI/LO update must land on the same edge as the accept (MTHI/MTLO) or
  // the mult_end sample (MULT/MADD), so the command is decoded combinationally.
  always_comb begin
    hilo_cmd = HILO_NONE;
    if (state_reg == ST_IDLE) begin
      if (req_valid) begin
        case (op_in)
          OP_MTHI: hilo_cmd = HILO_WR_HI;
          OP_MTLO: hilo_cmd = HILO_WR_LO;
          default: hilo_cmd = HILO_NONE;
        endcase
      end
    end else if (mult_end) begin
`ifdef MULT_HILO_MADD_EN
      hilo_cmd = madd_reg ? HILO_ACC : HILO_LOAD;
`else
      hilo_cmd = HILO_LOAD;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mult_begin_reg <= 1'b0;
      op1_reg        <= 32'd0;
      op2_reg        <= 32'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      wd_cnt_reg     <= '0;
`ifdef MULT_HILO_MADD_EN
      madd_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            case (op_in)
              OP_MTHI, OP_MTLO: done_reg <= 1'b1;
              OP_MULT: begin
                op1_reg        <= req_src1;
                op2_reg        <= req_src2;
                mult_begin_reg <= 1'b1;
                wd_cnt_reg     <= '0;
`ifdef MULT_HILO_MADD_EN
                madd_reg       <= 1'b0;
`endif
                state_reg      <= ST_BUSY;
              end
              default: begin  // OP_MADD
`ifdef MULT_HILO_MADD_EN
                op1_reg        <= req_src1;
                op2_reg        <= req_src2;
                mult_begin_reg <= 1'b1;
                wd_cnt_reg     <= '0;
                madd_reg       <= 1'b1;
                state_reg      <= ST_BUSY;
`else
                done_reg       <= 1'b1;
`endif
              end
            endcase
          end
        end
        ST_BUSY: begin
          // mult_end takes priority over a simultaneous watchdog expiry.
          if (mult_end) begin
            mult_begin_reg <= 1'b0;
            done_reg       <= 1'b1;
            state_reg      <= ST_IDLE;
          end else if (wd_cnt_reg == WD_LAST) begin
            mult_begin_reg <= 1'b0;
            err_reg        <= 1'b1;
            state_reg      <= ST_IDLE;
          end else begin
            wd_cnt_reg     <= wd_cnt_reg + 1'b1;
          end
        end
        default: begin
          mult_begin_reg <= 1'b0;
          state_reg      <= ST_IDLE;
        end
      endcase
    end
  end

  hilo_reg u_hilo (
    .clk   (clk),
    .rst   (rst),
    .cmd   (hilo_cmd),
    .wdata (req_src1),
    .prod  (product),
    .hi    (hi),
    .lo    (lo)
  );

  assign req_ready  = (state_reg == ST_IDLE);
  assign mult_begin = mult_begin_reg;
  assign mult_op1   = op1_reg;
  assign mult_op2   = op2_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_hilo_ctrl
// Directed bench for mult_hilo_ctrl with a simple behavioural multiplier whose
// mult_end latency is selectable per test. Honours MULT_HILO_MADD_EN.
// -----------------------------------------------------------------------------
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  // behavioural multiplier controls
  logic [4:0]  lat;
  logic        tie_off;
  logic        force_end;
  logic [63:0] force_prod;
  logic [4:0]  mcnt;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.WATCHDOG_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end),
    .hi         (hi),
    .lo         (lo),
    .done       (done),
    .err        (err)
  );

  // mult_end rises when mult_begin has been high for lat+1 cycles.
  always @(posedge clk) begin
    if (!mult_begin) mcnt <= 5'd0;
    else             mcnt <= mcnt + 5'd1;
  end

  assign mult_end = force_end | (mult_begin & ~tie_off & (mcnt == lat));
  assign product  = force_end ? force_prod
                  : $signed({{32{mult_op1[31]}}, mult_op1}) * $signed({{32{mult_op2[31]}}, mult_op2});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request; returns in cycle T+1 after the accept edge T.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    $display("req op=%0d src1=%h src2=%h accepted", op, a, b);
  endtask

  // Called in cycle T+1; returns in the cycle where done is seen (or at max).
  task automatic wait_done(input int max, output int cyc);
    cyc = 1;
    while (!done && cyc < max) begin
      tick();
      cyc++;
    end
    $display("done observed=%0b at T+%0d hi=%h lo=%h", done, cyc, hi, lo);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int n;
    logic saw_done;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
    lat = 5'd1; tie_off = 1'b0; force_end = 1'b0; force_prod = '0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_begin", 64'(mult_begin), 64'd0);
    chk("rst_op1", 64'(mult_op1), 64'd0);
    chk("rst_op2", 64'(mult_op2), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_ready", 64'(req_ready), 64'd1);

    // MULT 3 x -5, mult_end in T+4 -> done T+5
    lat = 5'd3;
    issue(2'b00, 32'd3, 32'hFFFF_FFFB);
    chk("t1_begin", 64'(mult_begin), 64'd1);
    chk("t1_ready_busy", 64'(req_ready), 64'd0);
    chk("t1_op1", 64'(mult_op1), 64'd3);
    chk("t1_op2", 64'(mult_op2), 64'hFFFF_FFFB);
    wait_done(20, c);
    chk("t1_done_cyc", 64'(c), 64'd5);
    chk("t1_begin_low", 64'(mult_begin), 64'd0);
    chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(lo), 64'hFFFF_FFF1);
    chk("t1_ready_at_done", 64'(req_ready), 64'd1);

    // MULT 7 x 0 issued in the done cycle, mult_end in T+2 -> done T+3
    lat = 5'd1;
    issue(2'b00, 32'd7, 32'd0);
    chk("t2_accept_after_done", 64'(mult_begin), 64'd1);
    chk("t2_done_pulse_ended", 64'(done), 64'd0);
    wait_done(20, c);
    chk("t2_done_cyc", 64'(c), 64'd3);
    chk("t2_hi", 64'(hi), 64'd0);
    chk("t2_lo", 64'(lo), 64'd0);
    tick();

    // MTHI then MTLO back-to-back
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'h1234_5678; req_src2 = 32'd0;
    tick();
    $display("req op=1 src1=12345678 accepted");
    chk("t3_hi", 64'(hi), 64'h1234_5678);
    chk("t3_done1", 64'(done), 64'd1);
    chk("t3_ready", 64'(req_ready), 64'd1);
    req_op = 2'b10; req_src1 = 32'h9ABC_DEF0;
    tick();
    $display("req op=2 src1=9abcdef0 accepted");
    req_valid = 1'b0;
    chk("t3_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("t3_hi_kept", 64'(hi), 64'h1234_5678);
    chk("t3_done2", 64'(done), 64'd1);
    chk("t3_no_begin", 64'(mult_begin), 64'd0);
    tick();
    chk("t3_done_off", 64'(done), 64'd0);

    // MADD 2 x 3 onto FFFFFFFF_FFFFFFFE
    issue(2'b01, 32'hFFFF_FFFF, 32'd0);
    issue(2'b10, 32'hFFFF_FFFE, 32'd0);
    lat = 5'd1;
    issue(2'b11, 32'd2, 32'd3);
`ifdef MULT_HILO_MADD_EN
    chk("t4_begin", 64'(mult_begin), 64'd1);
    wait_done(20, c);
    chk("t4_done_cyc", 64'(c), 64'd3);
    chk("t4_hilo", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_0004);
`else
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_no_begin", 64'(mult_begin), 64'd0);
    chk("t4_hilo", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t4_err", 64'(err), 64'd0);
`endif
    tick();

    // Watchdog abort with mult_end tied low
    issue(2'b01, 32'hA5A5_A5A5, 32'd0);
    issue(2'b10, 32'h5A5A_5A5A, 32'd0);
    tie_off = 1'b1;
    issue(2'b00, 32'd5, 32'd6);
    n = 1;
    saw_done = 1'b0;
    while (mult_begin && n < 100) begin
      if (done) saw_done = 1'b1;
      tick();
      n++;
    end
    $display("watchdog abort at T+%0d err=%0b", n, err);
    chk("t5_abort_cyc", 64'(n), 64'd33);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_ready", 64'(req_ready), 64'd1);
    chk("t5_no_done", 64'(saw_done | done), 64'd0);
    chk("t5_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("t5_lo", 64'(lo), 64'h5A5A_5A5A);
    tie_off = 1'b0;
    tick();
    chk("t5_err_sticky", 64'(err), 64'd1);

    // Reset in T+3 of MULT 0x80000000 x 0x80000000
    lat = 5'd3;
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    tick();
    tick();
    rst = 1'b1;
    #1;
    $display("rst asserted during BUSY");
    chk("t6_begin", 64'(mult_begin), 64'd0);
    chk("t6_op1", 64'(mult_op1), 64'd0);
    chk("t6_op2", 64'(mult_op2), 64'd0);
    chk("t6_hilo", {32'(hi), 32'(lo)}, 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    tick();
    rst = 1'b0;
    chk("t6_ready", 64'(req_ready), 64'd1);
    // stale mult_end while idle must be ignored
    force_prod = 64'hDEAD_BEEF_CAFE_F00D;
    force_end  = 1'b1;
    tick();
    force_end  = 1'b0;
    chk("t6_stale_hilo", {32'(hi), 32'(lo)}, 64'd0);
    chk("t6_stale_done", 64'(done), 64'd0);
    lat = 5'd1;
    issue(2'b00, 32'd2, 32'd2);
    wait_done(20, c);
    chk("t6_done_cyc", 64'(c), 64'd3);
    chk("t6_lo", 64'(lo), 64'd4);
    chk("t6_hi", 64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
